cnn_window_gen: RTL
===================

Name: cnn_window_gen

Overview:
- Upstream neighbour of the CNN core: converts a raster-order pixel stream into KX x KY sliding windows across all CI channels.
- Presents each window on the flat CI*KX*KY*I_F_BW bus the core consumes, with a single-cycle valid.
- Stride 1, no padding. Uses KY-1 line buffers plus a KY x KX register window.
- Runs frame after frame with no software intervention.

Parameters:
- CI, 3, input channels per pixel
- KX, 3, kernel width
- KY, 3, kernel height
- I_F_BW, 8, bits per channel sample (unsigned)
- IW, 28, image width in pixels (must be >= KX)
- IH, 28, image height in pixels (must be >= KY)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_soft_reset  in  1  synchronous clear; same effect as reset, one cycle
- i_in_valid  in  1  pixel-valid strobe; no backpressure
- i_in_pixel  in  CI*I_F_BW  one pixel; channel ci at [ci*I_F_BW +: I_F_BW]
- o_ot_valid  out  1  window valid, one-cycle pulse per window
- o_ot_fmap  out  CI*KX*KY*I_F_BW  window; sample (ci,ky,kx) at [((ci*KY+ky)*KX+kx)*I_F_BW +: I_F_BW]
- o_frame_done  out  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset (async, or i_soft_reset at a clock edge):
  - o_ot_valid=0, o_frame_done=0, o_ot_fmap=0.
  - Column counter col=0, row counter row=0.
  - Window registers and line buffers cleared to 0.
- State advances only on cycles with i_in_valid=1. Idle cycles hold all state and drive o_ot_valid=0.
- Per accepted pixel (row,col):
  - Each window row shifts left by one column. kx=KX-1 is the newest column; ky=KY-1 is the current row.
  - New column, ky=KY-1: i_in_pixel.
  - New column, ky<KY-1: line buffer (KY-2-ky) read at col, i.e. the pixel from row-(KY-1-ky).
  - Line buffers update as a cascade at address col: buffer 0 gets i_in_pixel; buffer k gets the old contents of buffer k-1.
- Counters:
  - col increments each accepted pixel and wraps IW-1 -> 0.
  - On col wrap, row increments; row wraps IH-1 -> 0. Frame boundary is implicit.
- Window emission:
  - When the accepted pixel has row>=KY-1 and col>=KX-1, o_ot_valid=1 on the next clock edge (latency 1 cycle from the accepting edge).
  - o_ot_fmap holds the completed window and stays stable until the next emission.
  - Windows per frame: (IW-KX+1)*(IH-KY+1).
- Row wrap: columns 0..KX-2 of each row never emit. Window columns carried over from the previous row are flushed by shifting and are never emitted.
- Frame done: o_frame_done=1 in the same cycle as o_ot_valid for the pixel (IH-1, IW-1). The next frame's first pixel may arrive on the following cycle with no bubble.
- Priority: reset > i_soft_reset > i_in_valid. A soft reset coincident with a valid pixel discards that pixel.
- Reset mid-frame: the partial frame is abandoned. The next accepted pixel is treated as (0,0).
- Line buffer depth: IW entries x CI*I_F_BW bits each; inferable as simple dual-port RAM or registers.
- Counter widths: $clog2(IW) and $clog2(IH). No arithmetic on pixel data; pure data movement.

Test Plan:
1. Basic 4x4 window extraction.
   - Setup: IW=IH=4, KX=KY=3, CI=1, I_F_BW=8. Stream pixels 1..16, back-to-back.
   - Expect exactly 4 o_ot_valid pulses, one cycle after pixels 11, 12, 15, 16.
   - First window, indices 0..8: 1,2,3,5,6,7,9,10,11.
   - Last window: 6,7,8,10,11,12,14,15,16.
   - o_frame_done high only with the 4th pulse.
2. Gapped input.
   - Same stream, with i_in_valid low for 1-3 random cycles between pixels.
   - Expect identical window contents and count. o_ot_valid never high during idle cycles.
3. Back-to-back frames.
   - Two frames, 1..16 then 101..116, with no gap.
   - Expect 8 windows. First window of frame 2 is 101,102,103,105,106,107,109,110,111; no frame-1 data leaks in.
4. Multi-channel packing.
   - CI=2. Channel 0 = n, channel 1 = n+128.
   - Expect window 1 channel 1 field (ci=1,ky=0,kx=0), at bit offset 9*8, to equal 129.
   - Expect all 18 fields correctly placed.
5. Reset mid-frame.
   - Assert reset asynchronously after pixel 7. Outputs go 0 immediately, without waiting for a clock edge.
   - Then stream 1..16: expect exactly the 4 windows of scenario 1.
6. Soft reset coincident with a valid pixel.
   - Assert i_soft_reset with pixel 5; the pixel is discarded.
   - Stream 1..16: expect the scenario 1 results. Expect no valid pulse within 1 cycle of the soft reset.

Source files
------------

// File: rtl/cnn_window_gen.sv
// Raster pixel stream to KX x KY sliding windows (stride 1, no padding) across CI channels.
// KY-1 line buffers feed the upper window rows; the newest row comes straight from the input.
module cnn_window_gen #(
  parameter int CI     = 3,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int IW     = 28,
  parameter int IH     = 28
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_soft_reset,
  input  logic                          i_in_valid,
  input  logic [CI*I_F_BW-1:0]          i_in_pixel,
  output logic                          o_ot_valid,
  output logic [CI*KX*KY*I_F_BW-1:0]    o_ot_fmap,
  output logic                          o_frame_done
);

  localparam int PW = CI*I_F_BW;
  localparam int CW = (IW > 1) ? $clog2(IW) : 1;
  localparam int RW = (IH > 1) ? $clog2(IH) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [KY-1:0][KX-1:0][PW-1:0] win, win_nxt;
  logic [KY-2:0][IW-1:0][PW-1:0] lb;
  logic [CI*KX*KY*I_F_BW-1:0]    fmap_nxt;
  logic emit, last;

  assign emit = i_in_valid && (row >= RW'(KY-1)) && (col >= CW'(KX-1));
  assign last = (row == RW'(IH-1)) && (col == CW'(IW-1));

  // kx=KX-1 is the newest column; upper rows come from older line buffers
  for (genvar ky = 0; ky < KY; ky++) begin : g_row
    for (genvar kx = 0; kx < KX-1; kx++) begin : g_shift
      assign win_nxt[ky][kx] = win[ky][kx+1];
    end
    if (ky == KY-1) begin : g_new
      assign win_nxt[ky][KX-1] = i_in_pixel;
    end else begin : g_lb
      assign win_nxt[ky][KX-1] = lb[KY-2-ky][col];
    end
  end

  for (genvar ci = 0; ci < CI; ci++) begin : g_ci
    for (genvar ky = 0; ky < KY; ky++) begin : g_ky
      for (genvar kx = 0; kx < KX; kx++) begin : g_kx
        assign fmap_nxt[((ci*KY+ky)*KX+kx)*I_F_BW +: I_F_BW] = win_nxt[ky][kx][ci*I_F_BW +: I_F_BW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0; row <= '0; win <= '0; lb <= '0;
      o_ot_valid <= 1'b0; o_frame_done <= 1'b0; o_ot_fmap <= '0;
    end else if (i_soft_reset) begin
      col <= '0; row <= '0; win <= '0; lb <= '0;
      o_ot_valid <= 1'b0; o_frame_done <= 1'b0; o_ot_fmap <= '0;
    end else begin
      o_ot_valid   <= emit;
      o_frame_done <= emit && last;
      if (i_in_valid) begin
        win <= win_nxt;
        if (emit) o_ot_fmap <= fmap_nxt;
        // line-buffer cascade: each buffer ages by one row at this column
        lb[0][col] <= i_in_pixel;
        for (int k = 1; k < KY-1; k++) lb[k][col] <= lb[k-1][col];
        if (col == CW'(IW-1)) begin
          col <= '0;
          row <= (row == RW'(IH-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
